uart_tx_arbiter: RTL and testbench

Shares the single uart_tx byte transmitter between N_REQ message sources, for example the message-buffer/ROM sender and the frequency-comparator reporter. Arbitration is round-robin and packet-atomic: a granted source keeps the UART until its byte marked last has been handed off. The block sits between the requesters and the uart_tx instance's tx_data / tx_data_valid / tx_data_ready port.

---
 rtl/uart_arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter and its helpers.
// ST_PREFIX is only reached when UART_ARB_ID_PREFIX_EN is defined.
package uart_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_POP    = 3'd1,
      ST_SEND   = 3'd2,
      ST_GAP    = 3'd3,
      ST_PREFIX = 3'd4
   } arb_state_t;

   localparam logic [7:0] ASCII_ZERO = 8'h30;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Kept generic so other shared resources can reuse it.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic             valid
);

   logic             found;
   logic [PTR_W-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = PTR_W'((int'(ptr) + i) % N_REQ);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one uart_tx between N_REQ sources.
// Optional UART_ARB_ID_PREFIX_EN: send ASCII owner index as a header byte per packet.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no owner; arbitrate among req_valid from ptr
// ST_PREFIX | load header byte '0'+owner (only with UART_ARB_ID_PREFIX_EN)
// ST_POP    | wait for owner's byte, pop it; timeout counter runs here only
// ST_SEND   | tx_data_valid high, waiting for tx_data_ready
// ST_GAP    | one cycle with tx_data_valid low; release on last byte
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = 27_000_000,
   parameter int TO_W           = 25
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic [7:0]         tx_data,
   output logic               tx_data_valid,
   input  logic               tx_data_ready,
   output logic [N_REQ-1:0]   grant,
   output logic               busy,
   output logic               timeout_err
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   arb_state_t       state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [N_REQ-1:0] ready_q, ready_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             last_q, last_d;
   logic             terr_q, terr_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

   logic [N_REQ-1:0] pick_grant;
   logic             pick_valid;
   logic [PTR_W-1:0] g_idx;
   logic [PTR_W-1:0] ptr_nxt;
   logic [7:0]       req_byte [N_REQ];
   logic             rel;

   rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr_pick (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .valid (pick_valid)
   );

   always_comb begin
      g_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_byte[i] = req_data[8*i +: 8];
         if (grant_q[i]) g_idx = PTR_W'(i);
      end
   end

   assign ptr_nxt = (g_idx == PTR_W'(N_REQ-1)) ? '0 : g_idx + 1'b1;

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      ready_d  = '0;
      ptr_d    = ptr_q;
      data_d   = data_q;
      valid_d  = valid_q;
      busy_d   = busy_q;
      last_d   = last_q;
      terr_d   = 1'b0;
      to_cnt_d = to_cnt_q;
      rel      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               grant_d  = pick_grant;
               busy_d   = 1'b1;
               to_cnt_d = '0;
`ifdef UART_ARB_ID_PREFIX_EN
               state_d  = ST_PREFIX;
`else
               state_d  = ST_POP;
`endif
            end
         end
`ifdef UART_ARB_ID_PREFIX_EN
         ST_PREFIX: begin
            data_d   = ASCII_ZERO + 8'(g_idx);
            last_d   = 1'b0;
            valid_d  = 1'b1;
            to_cnt_d = '0;
            state_d  = ST_SEND;
         end
`endif
         ST_POP: begin
            if (req_valid[g_idx]) begin
               ready_d  = grant_q;
               data_d   = req_byte[g_idx];
               last_d   = req_last[g_idx];
               valid_d  = 1'b1;
               to_cnt_d = '0;
               state_d  = ST_SEND;
            end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES-1)) begin
               terr_d = 1'b1;
               rel    = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         ST_SEND: begin
            if (tx_data_ready) begin
               valid_d = 1'b0;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (last_q) rel     = 1'b1;
            else        state_d = ST_POP;
         end
         default: state_d = ST_IDLE;
      endcase

      // Release is shared by end-of-packet and timeout; ptr moves past the owner.
      if (rel) begin
         grant_d  = '0;
         busy_d   = 1'b0;
         ptr_d    = ptr_nxt;
         to_cnt_d = '0;
         state_d  = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         ready_q  <= '0;
         ptr_q    <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         last_q   <= 1'b0;
         terr_q   <= 1'b0;
         to_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         ready_q  <= ready_d;
         ptr_q    <= ptr_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         last_q   <= last_d;
         terr_q   <= terr_d;
         to_cnt_q <= to_cnt_d;
      end
   end

   assign req_ready     = ready_q;
   assign tx_data       = data_q;
   assign tx_data_valid = valid_q;
   assign grant         = grant_q;
   assign busy          = busy_q;
   assign timeout_err   = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table of packet loads and expected UART bytes,
// plus hand sequences for release timing, timeout and reset during SEND.
module tb_uart_tx_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic [7:0]     tx_data;
   logic           tx_data_valid;
   logic           tx_data_ready;
   logic [N-1:0]   grant;
   logic           busy;
   logic           timeout_err;

   uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(16), .TO_W(5)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .tx_data       (tx_data),
      .tx_data_valid (tx_data_valid),
      .tx_data_ready (tx_data_ready),
      .grant         (grant),
      .busy          (busy),
      .timeout_err   (timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct { int scen; int src; logic [7:0] data; logic last; } load_t;
   typedef struct { int scen; int src; logic [7:0] data; logic first; } exp_t;

   load_t loads [16];
   exp_t  exps  [16];
   int    n_loads = 0;
   int    n_exps  = 0;

   int compared   = 0;
   int mismatched = 0;

   logic [8:0] rmem [N][8];
   int         rhead [N];
   int         rcnt  [N];
   int         pops  [N];

   int         hold_cfg = 0;
   int         hold = 0;
   bit         uart_block = 1'b0;
   logic [7:0] acc_byte [64];
   int         acc_src [64];
   int         acc_cyc [64];
   int         acc_n = 0;

   logic       busy_hist  [4096];
   logic [3:0] grant_hist [4096];
   int         cyc = 0;
   int         to_pulses = 0;
   int         to_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      compared++;
      if (act !== exp_v) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   function automatic int oh_idx(input logic [N-1:0] oh);
      for (int i = 0; i < N; i++) if (oh[i]) return i;
      return -1;
   endfunction

   function automatic bit queues_empty();
      for (int i = 0; i < N; i++) if (rcnt[i] != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic clear_queues();
      for (int i = 0; i < N; i++) begin
         rcnt[i]  = 0;
         rhead[i] = 0;
      end
   endtask

   // Requester and uart_tx models, all driven on the falling edge.
   initial begin
      req_valid     = '0;
      req_data      = '0;
      req_last      = '0;
      tx_data_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         rhead[i] = 0;
         rcnt[i]  = 0;
         pops[i]  = 0;
      end
      forever begin
         @(negedge clk);
         cyc++;
         busy_hist[cyc % 4096]  = busy;
         grant_hist[cyc % 4096] = grant;
         if (timeout_err) begin
            to_pulses++;
            to_cyc = cyc;
         end
         if (req_ready != '0)
            check("req_ready_owner", 32'(((req_ready & ~grant) == '0) && $onehot(req_ready)), 32'd1);
         for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
               pops[i]++;
               if (rcnt[i] > 0) begin
                  rhead[i] = (rhead[i] + 1) % 8;
                  rcnt[i]--;
               end
            end
            req_valid[i]       = (rcnt[i] > 0);
            req_data[8*i +: 8] = (rcnt[i] > 0) ? rmem[i][rhead[i]][7:0] : 8'h00;
            req_last[i]        = (rcnt[i] > 0) ? rmem[i][rhead[i]][8] : 1'b0;
         end
         if (hold > 0) begin
            tx_data_ready = 1'b0;
            hold--;
         end else begin
            tx_data_ready = !uart_block;
         end
         if (tx_data_ready && tx_data_valid) begin
            if (acc_n < 64) begin
               acc_byte[acc_n] = tx_data;
               acc_src[acc_n]  = oh_idx(grant);
               acc_cyc[acc_n]  = cyc;
               acc_n++;
            end
            hold = hold_cfg;
         end
      end
   end

   task automatic apply_reset();
      rst_n = 1'b0;
      clear_queues();
      hold       = 0;
      uart_block = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic run_scen(input int s, input bit do_reset, input int hold_c);
      logic [7:0] eb [32];
      int         es [32];
      int         n;
      int         budget;
      int         src;
      if (do_reset) apply_reset();
      hold_cfg  = hold_c;
      acc_n     = 0;
      to_pulses = 0;
      for (int i = 0; i < N; i++) pops[i] = 0;
      n = 0;
      for (int e = 0; e < n_exps; e++) begin
         if (exps[e].scen == s) begin
`ifdef UART_ARB_ID_PREFIX_EN
            if (exps[e].first) begin
               eb[n] = 8'h30 + 8'(exps[e].src);
               es[n] = exps[e].src;
               n++;
            end
`endif
            eb[n] = exps[e].data;
            es[n] = exps[e].src;
            n++;
         end
      end
      @(negedge clk);
      #1;
      for (int l = 0; l < n_loads; l++) begin
         if (loads[l].scen == s) begin
            src = loads[l].src;
            rmem[src][(rhead[src] + rcnt[src]) % 8] = {loads[l].last, loads[l].data};
            rcnt[src]++;
         end
      end
      budget = 0;
      while (!(acc_n >= n && busy == 1'b0 && queues_empty()) && budget < 3000) begin
         @(negedge clk);
         #1;
         budget++;
      end
      check($sformatf("s%0d_done", s), 32'(budget < 3000), 32'd1);
      check($sformatf("s%0d_count", s), 32'(acc_n), 32'(n));
      for (int k = 0; k < n; k++) begin
         check($sformatf("s%0d_byte%0d", s, k), 32'(acc_byte[k]), 32'(eb[k]));
         check($sformatf("s%0d_src%0d", s, k), 32'(acc_src[k]), 32'(es[k]));
      end
   endtask

   initial begin
      int lc;
      int k90;
      int b;

      loads[0]  = '{1, 0, 8'h41, 1'b0};
      loads[1]  = '{1, 0, 8'h42, 1'b0};
      loads[2]  = '{1, 0, 8'h0A, 1'b1};
      loads[3]  = '{2, 0, 8'h10, 1'b0};
      loads[4]  = '{2, 0, 8'h11, 1'b1};
      loads[5]  = '{2, 2, 8'h20, 1'b0};
      loads[6]  = '{2, 2, 8'h21, 1'b1};
      loads[7]  = '{3, 0, 8'h05, 1'b1};
      loads[8]  = '{3, 3, 8'h30, 1'b1};
      loads[9]  = '{4, 1, 8'h61, 1'b0};
      loads[10] = '{4, 1, 8'h62, 1'b0};
      loads[11] = '{4, 1, 8'h63, 1'b1};
      loads[12] = '{4, 3, 8'h71, 1'b1};
      loads[13] = '{5, 0, 8'h90, 1'b0};
      loads[14] = '{5, 1, 8'h91, 1'b1};
      loads[15] = '{6, 2, 8'hAA, 1'b1};
      n_loads = 16;

      exps[0]  = '{1, 0, 8'h41, 1'b1};
      exps[1]  = '{1, 0, 8'h42, 1'b0};
      exps[2]  = '{1, 0, 8'h0A, 1'b0};
      exps[3]  = '{2, 0, 8'h10, 1'b1};
      exps[4]  = '{2, 0, 8'h11, 1'b0};
      exps[5]  = '{2, 2, 8'h20, 1'b1};
      exps[6]  = '{2, 2, 8'h21, 1'b0};
      exps[7]  = '{3, 3, 8'h30, 1'b1};
      exps[8]  = '{3, 0, 8'h05, 1'b1};
      exps[9]  = '{4, 1, 8'h61, 1'b1};
      exps[10] = '{4, 1, 8'h62, 1'b0};
      exps[11] = '{4, 1, 8'h63, 1'b0};
      exps[12] = '{4, 3, 8'h71, 1'b1};
      exps[13] = '{5, 0, 8'h90, 1'b1};
      exps[14] = '{5, 1, 8'h91, 1'b1};
      exps[15] = '{6, 2, 8'hAA, 1'b1};
      n_exps = 16;

      apply_reset();
      @(negedge clk);
      #1;
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(tx_data_valid), 32'd0);
      check("rst_data", 32'(tx_data), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_terr", 32'(timeout_err), 32'd0);

      // Single source with a slow UART; release two cycles after the last accept.
      run_scen(1, 1'b1, 10);
      check("s1_pops", 32'(pops[0]), 32'd3);
      lc = acc_cyc[(acc_n > 0) ? acc_n - 1 : 0];
      check("s1_gap_busy", 32'(busy_hist[(lc + 1) % 4096]), 32'd1);
      check("s1_rel_busy", 32'(busy_hist[(lc + 2) % 4096]), 32'd0);
      check("s1_rel_grant", 32'(grant_hist[(lc + 2) % 4096]), 32'd0);

      // Simultaneous 0 and 2, then 0 and 3 without reset: pointer now at 3.
      run_scen(2, 1'b1, 0);
      run_scen(3, 1'b0, 0);

      // Requester 3 waits while requester 1 owns the UART.
      run_scen(4, 1'b1, 3);
      check("s4_pops1", 32'(pops[1]), 32'd3);
      check("s4_pops3", 32'(pops[3]), 32'd1);

      // Requester 0 stalls mid-packet; forced release hands over to 1.
      run_scen(5, 1'b1, 0);
      k90 = 0;
      for (int k = acc_n - 1; k >= 0; k--) if (acc_byte[k] == 8'h90) k90 = k;
      check("s5_terr_pulses", 32'(to_pulses), 32'd1);
      check("s5_terr_time", 32'(to_cyc), 32'(acc_cyc[k90] + 18));
      check("s5_terr_grant", 32'(grant_hist[to_cyc % 4096]), 32'd0);
      check("s5_pops0", 32'(pops[0]), 32'd1);

      // Move ptr to 3, then reset while stuck in SEND; ptr must return to 0.
      run_scen(6, 1'b1, 0);
      uart_block = 1'b1;
      @(negedge clk);
      #1;
      rmem[2][(rhead[2] + rcnt[2]) % 8] = {1'b1, 8'hAB};
      rcnt[2]++;
      b = 0;
      while (!tx_data_valid && b < 50) begin
         @(negedge clk);
         #1;
         b++;
      end
      check("s6_reached_send", 32'(tx_data_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("s6_rst_valid", 32'(tx_data_valid), 32'd0);
      check("s6_rst_grant", 32'(grant), 32'd0);
      check("s6_rst_busy", 32'(busy), 32'd0);
      clear_queues();
      hold       = 0;
      uart_block = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b1;
      n_loads = 0;
      loads[n_loads++] = '{7, 3, 8'hB3, 1'b1};
      loads[n_loads++] = '{7, 1, 8'hB1, 1'b1};
      loads[n_loads++] = '{8, 2, 8'h58, 1'b1};
      n_exps = 0;
      exps[n_exps++] = '{7, 1, 8'hB1, 1'b1};
      exps[n_exps++] = '{7, 3, 8'hB3, 1'b1};
      exps[n_exps++] = '{8, 2, 8'h58, 1'b1};
      run_scen(7, 1'b0, 0);

      // Single-byte packet "X" from requester 2 (header '2' first when enabled).
      run_scen(8, 1'b1, 0);
      check("s8_pops2", 32'(pops[2]), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
